// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and per-layer geometry for the CNN feature-map memories
//
// Contents:
//   FMAP_DATA_W / FMAP_ROWS / FMAP_COLS / FMAP_ADDR_W : default layer geometry
//   fmap_word_t    : one feature-map word (channels x 16-bit activations)
//   stream_state_t : raster stream FSM states
//   clog2_min1     : index width helper that never returns zero
package cnn_pkg;

    localparam int FMAP_DATA_W = 128;
    localparam int FMAP_ROWS   = 8;
    localparam int FMAP_COLS   = 8;
    localparam int FMAP_ADDR_W = 16;

    typedef logic [FMAP_DATA_W-1:0] fmap_word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // A one-entry dimension still needs a 1-bit counter/index.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_bank.sv
// rtl/fmap_bank.sv - one feature-map bank: write port, registered read port, combinational stream port
//
// Ports:
//   clk                         : clock
//   wr_en / wr_idx / wr_data    : write port (flat row*COLS+col index)
//   rd_en / rd_idx / rd_data    : random-read port, data registered one cycle after rd_en
//   st_idx / st_data            : stream-read port, data follows st_idx combinationally
module fmap_bank
    import cnn_pkg::*;
#(
    parameter int DATA_W = FMAP_DATA_W,
    parameter int DEPTH  = FMAP_ROWS * FMAP_COLS,
    parameter int IDX_W  = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  st_idx,
    output logic [DATA_W-1:0] st_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; the caller gates rd_data with its own valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

    assign st_data = mem[st_idx];

endmodule

// File: rtl/cnn_fmap_pingpong_mem.sv
// rtl/cnn_fmap_pingpong_mem.sv - double-buffered feature-map memory with random-read and raster-stream drain
//
// Ports:
//   clk, rst (async, active-high)
//   wr_en/wr_row/wr_col/wr_data : write into the current write bank
//   wr_commit                   : hand the write bank to the reader side
//   wr_ready, wr_oob            : write bank empty; sticky out-of-range write flag
//   rd_en/rd_row/rd_col         : random read of the read bank (1-cycle latency)
//   rd_release                  : random-mode reader gives the read bank back
//   rd_avail, rd_valid, rd_data : read bank committed; random-read result
//   stream_start                : start a raster stream of the read bank
//   out_valid/out_ready/out_data/out_last : raster stream, out_last on (ROWS-1, COLS-1)
//   stream_busy                 : stream in progress
module cnn_fmap_pingpong_mem
    import cnn_pkg::*;
#(
    parameter int DATA_W = FMAP_DATA_W,
    parameter int ROWS   = FMAP_ROWS,
    parameter int COLS   = FMAP_COLS,
    parameter int ADDR_W = FMAP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [ADDR_W-1:0] wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    output logic              wr_oob,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_row,
    input  logic [ADDR_W-1:0] rd_col,
    input  logic              rd_release,
    output logic              rd_avail,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              stream_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              stream_busy
);

    localparam int DEPTH = ROWS * COLS;
    localparam int IDX_W = clog2_min1(DEPTH);
    localparam int ROW_W = clog2_min1(ROWS);
    localparam int COL_W = clog2_min1(COLS);

    stream_state_t     state, state_n;
    logic [ROW_W-1:0]  r_cnt, r_cnt_n;
    logic [COL_W-1:0]  c_cnt, c_cnt_n;
    logic              wr_bank, rd_bank, rd_sel;
    logic [1:0]        full, full_n;
    logic              wr_in_range, rd_in_range, wr_hit, rd_hit;
    logic              commit, rd_done, frame_done, at_last;
    logic [IDX_W-1:0]  wr_idx, rd_idx, st_idx;
    logic [DATA_W-1:0] bank_rd [2];
    logic [DATA_W-1:0] bank_st [2];

    assign wr_ready    = !full[wr_bank];
    assign rd_avail    = full[rd_bank];
    assign stream_busy = (state == STREAM);

    assign wr_in_range = (wr_row < ADDR_W'(ROWS)) && (wr_col < ADDR_W'(COLS));
    assign rd_in_range = (rd_row < ADDR_W'(ROWS)) && (rd_col < ADDR_W'(COLS));
    assign wr_idx      = IDX_W'(32'(wr_row) * COLS + 32'(wr_col));
    assign rd_idx      = IDX_W'(32'(rd_row) * COLS + 32'(rd_col));
    assign st_idx      = IDX_W'(32'(r_cnt) * COLS + 32'(c_cnt));

    assign wr_hit  = wr_en && wr_ready && wr_in_range;
    assign rd_hit  = rd_en && rd_avail && (state == IDLE) && rd_in_range;
    assign commit  = wr_commit && wr_ready;
    assign rd_done = (rd_release && rd_avail && (state == IDLE)) || frame_done;
    assign at_last = (r_cnt == ROW_W'(ROWS - 1)) && (c_cnt == COL_W'(COLS - 1));

    // Commit needs full[wr_bank]=0 and release needs full[rd_bank]=1, so when the
    // pointers coincide the two updates can never target the same flag together.
    always_comb begin
        full_n = full;
        if (commit) begin
            full_n[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_n[rd_bank] = 1'b0;
        end
    end

    always_comb begin
        state_n    = state;
        r_cnt_n    = r_cnt;
        c_cnt_n    = c_cnt;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (stream_start && rd_avail) begin
                    state_n = STREAM;
                    r_cnt_n = '0;
                    c_cnt_n = '0;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = at_last;
                if (out_ready) begin
                    if (at_last) begin
                        state_n    = IDLE;
                        frame_done = 1'b1;
                        r_cnt_n    = '0;
                        c_cnt_n    = '0;
                    end else if (c_cnt == COL_W'(COLS - 1)) begin
                        c_cnt_n = '0;
                        r_cnt_n = r_cnt + ROW_W'(1);
                    end else begin
                        c_cnt_n = c_cnt + COL_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r_cnt <= '0;
            c_cnt <= '0;
        end else begin
            state <= state_n;
            r_cnt <= r_cnt_n;
            c_cnt <= c_cnt_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= '0;
            wr_oob   <= 1'b0;
            rd_valid <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            full     <= full_n;
            rd_valid <= rd_hit;
            // Remember the bank the read came from: a same-cycle release flips rd_bank.
            rd_sel   <= rd_bank;
            if (commit) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
            if (wr_en && wr_ready && !wr_in_range) begin
                wr_oob <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fmap_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_hit && (wr_bank == 1'(g))),
            .wr_idx  (wr_idx),
            .wr_data (wr_data),
            .rd_en   (rd_hit && (rd_bank == 1'(g))),
            .rd_idx  (rd_idx),
            .rd_data (bank_rd[g]),
            .st_idx  (st_idx),
            .st_data (bank_st[g])
        );
    end

    assign rd_data  = rd_valid  ? bank_rd[rd_sel]  : '0;
    assign out_data = out_valid ? bank_st[rd_bank] : '0;

endmodule

// File: tb/tb_cnn_fmap_pingpong_mem.sv
// tb/tb_cnn_fmap_pingpong_mem.sv - self-checking bench for cnn_fmap_pingpong_mem
module tb_cnn_fmap_pingpong_mem;
    import cnn_pkg::*;

    localparam int R  = FMAP_ROWS;
    localparam int C  = FMAP_COLS;
    localparam int AW = FMAP_ADDR_W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en, wr_commit, rd_en, rd_release, stream_start, out_ready;
    logic [AW-1:0] wr_row, wr_col, rd_row, rd_col;
    fmap_word_t    wr_data, rd_data, out_data;
    logic          wr_ready, wr_oob, rd_avail, rd_valid, out_valid, out_last, stream_busy;

    always #5 clk = ~clk;

    cnn_fmap_pingpong_mem dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .wr_commit    (wr_commit),
        .wr_ready     (wr_ready),
        .wr_oob       (wr_oob),
        .rd_en        (rd_en),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_release   (rd_release),
        .rd_avail     (rd_avail),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .stream_start (stream_start),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .stream_busy  (stream_busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: banks as 2-D arrays, ownership flags, and the frame in
    // flight as a queue of words still to be delivered.
    fmap_word_t mm [2][R][C];
    bit         full_m [2];
    int         wb, rb;
    fmap_word_t sq [$];
    bit         rv_m;
    fmap_word_t rd_m;
    bit         oob_m;

    task automatic check(input string tag, input fmap_word_t got, input fmap_word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic fmap_word_t rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 15) == 0) return AW'($urandom_range(8, 65535));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic idle();
        wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0; stream_start = 0; out_ready = 0;
        wr_row = '0; wr_col = '0; rd_row = '0; rd_col = '0; wr_data = '0;
    endtask

    // Called at a falling edge with inputs set: checks outputs, then advances the model.
    task automatic step();
        bit wrdy, ravl, busy, endf, rel, strt;
        #1;
        wrdy = !full_m[wb];
        ravl = full_m[rb];
        busy = (sq.size() != 0);
        check("wr_ready",    wr_ready,    wrdy);
        check("rd_avail",    rd_avail,    ravl);
        check("stream_busy", stream_busy, busy);
        check("out_valid",   out_valid,   busy);
        check("out_data",    out_data,    busy ? sq[0] : '0);
        check("out_last",    out_last,    busy && (sq.size() == 1));
        check("rd_valid",    rd_valid,    rv_m);
        check("rd_data",     rd_data,     rd_m);
        check("wr_oob",      wr_oob,      oob_m);

        rv_m = rd_en && ravl && !busy && (rd_row < R) && (rd_col < C);
        rd_m = '0;
        if (rv_m) rd_m = mm[rb][rd_row][rd_col];
        endf = 0;
        if (busy && out_ready) begin
            void'(sq.pop_front());
            endf = (sq.size() == 0);
        end
        rel  = rd_release && ravl && !busy;
        strt = stream_start && ravl && !busy;
        if (strt) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    sq.push_back(mm[rb][r][c]);
        end
        if (wr_en && wrdy) begin
            if (wr_row < R && wr_col < C) mm[wb][wr_row][wr_col] = wr_data;
            else oob_m = 1;
        end
        if (wr_commit && wrdy) begin
            full_m[wb] = 1;
            wb ^= 1;
        end
        if (rel || endf) begin
            full_m[rb] = 0;
            rb ^= 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        #1;
        full_m[0] = 0; full_m[1] = 0; wb = 0; rb = 0;
        sq.delete(); rv_m = 0; rd_m = '0; oob_m = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic fill(input bit pattern, input bit commit);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                wr_en     = 1;
                wr_row    = AW'(r);
                wr_col    = AW'(c);
                wr_data   = pattern ? fmap_word_t'(r * 16 + c) : rnd_word();
                wr_commit = commit && (r == R - 1) && (c == C - 1);
                step();
            end
        end
        idle();
    endtask

    task automatic run_stream(input bit toggle, input fmap_word_t first_exp);
        int n = 0;
        stream_start = 1;
        step();
        idle();
        #1;
        check("first_word", out_data, first_exp);
        while (sq.size() != 0 && n < 400) begin
            out_ready = toggle ? ~n[0] : 1'b1;
            step();
            n++;
        end
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();
        #1;
        check("rst_wr_ready",  wr_ready,    1);
        check("rst_out_valid", out_valid,   0);
        check("rst_rd_avail",  rd_avail,    0);
        step();

        // Pattern fill of bank 0, random read at (3,5).
        fill(1, 1);
        #1;
        check("fill_rd_avail", rd_avail, 1);
        check("fill_wr_ready", wr_ready, 1);
        rd_en = 1; rd_row = 3; rd_col = 5;
        step();
        idle();
        #1;
        check("rd_35", rd_data, fmap_word_t'('h35));
        step();

        // Stalling stream of bank 0.
        run_stream(1, '0);
        #1;
        check("s1_rd_avail", rd_avail,    0);
        check("s1_busy",     stream_busy, 0);
        step();

        // Both banks full; dropped write must not corrupt bank 0.
        fill(0, 1);
        fill(1, 1);
        #1;
        check("both_full_wr_ready", wr_ready, 0);
        wr_en = 1; wr_row = 0; wr_col = 0; wr_data = fmap_word_t'('hAA);
        step();
        idle();
        run_stream(0, mm[1][0][0]);
        run_stream(0, '0);

        // Out-of-range write, then commit.
        wr_en = 1; wr_row = 8; wr_col = 2; wr_data = rnd_word();
        step();
        idle();
        #1;
        check("oob_set", wr_oob, 1);
        wr_commit = 1;
        step();
        idle();
        #1;
        check("oob_sticky", wr_oob, 1);
        step();

        // Concurrent fill of bank 1 while streaming bank 0; commit meets final accept.
        do_reset();
        fill(0, 1);
        stream_start = 1;
        step();
        idle();
        for (int i = 0; i < R * C; i++) begin
            out_ready = 1;
            wr_en     = 1;
            wr_row    = AW'(i / C);
            wr_col    = AW'(i % C);
            wr_data   = rnd_word();
            wr_commit = (i == R * C - 1);
            step();
        end
        idle();
        #1;
        check("conc_rd_avail", rd_avail,    1);
        check("conc_wr_ready", wr_ready,    1);
        check("conc_busy",     stream_busy, 0);
        step();

        // Reset after 20 stream words.
        stream_start = 1;
        step();
        idle();
        for (int i = 0; i < 20; i++) begin
            out_ready = 1;
            step();
        end
        do_reset();
        #1;
        check("mrst_out_valid", out_valid,   0);
        check("mrst_busy",      stream_busy, 0);
        check("mrst_rd_avail",  rd_avail,    0);
        check("mrst_wr_ready",  wr_ready,    1);
        stream_start = 1;
        step();
        idle();
        step();
        #1;
        check("mrst_start_ignored", stream_busy, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            wr_en        = ($urandom_range(0, 9) < 7);
            wr_row       = rnd_addr();
            wr_col       = rnd_addr();
            wr_data      = rnd_word();
            wr_commit    = ($urandom_range(0, 31) == 0);
            rd_en        = ($urandom_range(0, 2) == 0);
            rd_row       = rnd_addr();
            rd_col       = rnd_addr();
            stream_start = ($urandom_range(0, 19) == 0);
            rd_release   = !stream_start && ($urandom_range(0, 29) == 0);
            out_ready    = ($urandom_range(0, 9) < 6);
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_fmap_pingpong_mem.md
Name: cnn_fmap_pingpong_mem

Overview:
Parametrised, double-buffered feature-map result memory for the CNN layer pipeline. It replaces the per-layer single-bank result memories. A layer engine fills one bank by (row, col) while the next layer drains the other bank, either by random-access reads or by a raster-order valid/ready stream. Bank ownership swaps through explicit commit and release events.

Parameters:
DATA_W, 128, word width (channels x 16-bit activations)
ROWS, 8, feature-map rows per bank
COLS, 8, feature-map columns per bank
ADDR_W, 16, width of row/col address ports

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe
wr_row  in  ADDR_W  write row address
wr_col  in  ADDR_W  write column address
wr_data  in  DATA_W  write data
wr_commit  in  1  pulse: current write bank complete
wr_ready  out  1  write bank available (not full)
wr_oob  out  1  sticky: out-of-range write seen
rd_en  in  1  random-read strobe
rd_row  in  ADDR_W  read row address
rd_col  in  ADDR_W  read column address
rd_release  in  1  pulse: random-mode reader done with bank
rd_avail  out  1  read bank holds a committed frame
rd_valid  out  1  random-read data valid
rd_data  out  DATA_W  random-read data
stream_start  in  1  pulse: begin raster stream of read bank
out_valid  out  1  stream word valid
out_ready  in  1  stream consumer ready
out_data  out  DATA_W  stream word
out_last  out  1  final word of frame (row ROWS-1, col COLS-1)
stream_busy  out  1  stream FSM not IDLE

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clk is the clock.
- State: two banks of ROWS*COLS words; wr_bank, rd_bank pointers; full[1:0] flags.
- Reset values: wr_bank=0, rd_bank=0, full=0, FSM=IDLE, counters=0, wr_oob=0. All outputs 0 except wr_ready=1. Bank contents are not cleared.
- wr_ready = !full[wr_bank]. rd_avail = full[rd_bank].
- Write:
  - If wr_en && wr_ready and both addresses are in range, mem[wr_bank][wr_row][wr_col] is written at the clock edge.
  - An out-of-range write is dropped and sets wr_oob (cleared only by rst).
  - A write while wr_ready=0 is dropped silently.
- Commit:
  - wr_commit && wr_ready sets full[wr_bank] and toggles wr_bank.
  - wr_commit while wr_ready=0 is ignored.
  - A same-cycle wr_en is written to the old bank before the swap.
- Random read:
  - rd_en && rd_avail && FSM==IDLE && address in range gives rd_valid=1 and rd_data=word on the next cycle (1-cycle registered latency).
  - Otherwise rd_valid=0 and rd_data=0.
- Release:
  - rd_release && rd_avail && FSM==IDLE clears full[rd_bank] and toggles rd_bank.
  - rd_release under any other condition is ignored.
- Stream FSM, IDLE -> STREAM:
  - Transition on stream_start && rd_avail; r=c=0.
  - stream_start without rd_avail is ignored.
- Stream FSM, STREAM:
  - out_valid=1; out_data = mem[rd_bank][r][c], presented combinationally from the counters.
  - Handshake: out_valid && out_ready advances c; at c=COLS-1, c wraps to 0 and r increments.
  - out_data/out_last hold stable while out_ready=0.
  - On acceptance of the word with out_last=1: clear full[rd_bank], toggle rd_bank, return to IDLE.
- Random reads and rd_release are ignored while stream_busy=1.
- Simultaneous events:
  - A commit on wr_bank and a release/stream-end on rd_bank in the same cycle both take effect.
  - When wr_bank==rd_bank and that bank is empty, a commit makes it readable on the next cycle only; there is no same-cycle bypass.
- Throughput: one write and one read/stream word per cycle. Writing bank A while streaming bank B is fully concurrent.
- Reset mid-stream: FSM returns to IDLE, the frame is discarded, both banks become empty.

Decomposition:
- Shared package cnn_pkg:
  - fmap_word_t (DATA_W), the FSM state enum {IDLE, STREAM}.
  - Per-layer ROWS/COLS constants, which replace the current per-layer width/length macros.
- Natural sub-module: fmap_bank, one ROWS x COLS x DATA_W storage array with one write port, one registered random-read port and one combinational stream-read port. It is instantiated twice.
- Bank pointers, full flags and the stream FSM stay in the top level.

Test Plan:
- Fill bank 0 with data = row*16+col for all 8x8 addresses, commit -> rd_avail=1, wr_ready=1. rd_en at (3,5) -> rd_valid next cycle, rd_data=0x35.
- Stream bank 0 with out_ready toggling 1,0,1,... -> 64 words in raster order, each held while stalled. out_last only on word 63 (0x77). Then rd_avail=0 and stream_busy=0.
- Fill and commit both banks without reading -> wr_ready=0. A further write to (0,0) with 0xAA is dropped; a subsequent stream of bank 0 returns the original 0x00.
- Write to (8,2) -> no storage change, wr_oob=1 and it stays set after a later commit.
- During a bank-1 fill, stream bank 0 concurrently, with wr_commit and the final out_last acceptance in the same cycle -> full becomes {1,0}, wr_bank=0, rd_bank=1.
- Assert rst at word 20 of a stream -> next cycle: out_valid=0, stream_busy=0, rd_avail=0, wr_ready=1. stream_start then has no effect.
